// File: rtl/rob_param.sv
// Parameterised reorder buffer: in-order dispatch, multi-port writeback,
// and up to RW in-order retirements per cycle.
module rob_param #(
  parameter int DEPTH  = 16,
  parameter int NWB    = 3,
  parameter int RW     = 2,
  parameter int DATA_W = 32,
  parameter int PR_W   = 6,
  parameter int PC_W   = 12,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  logic [PR_W-1:0]       disp_rd,
  input  logic [PR_W-1:0]       disp_rd_old,
  input  logic [PC_W-1:0]       disp_pc,
  output logic [IDX_W-1:0]      disp_idx,
  input  logic [NWB-1:0]        wb_valid,
  input  logic [NWB*IDX_W-1:0]  wb_idx,
  input  logic [NWB*DATA_W-1:0] wb_data,
  output logic [RW-1:0]         ret_valid,
  output logic [RW*PR_W-1:0]    ret_rd,
  output logic [RW*PR_W-1:0]    ret_rd_old,
  output logic [RW*DATA_W-1:0]  ret_data,
  output logic [RW*PC_W-1:0]    ret_pc,
  input  logic                  flush,
  output logic [IDX_W:0]        count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [IDX_W:0] DEPTH_C =
    (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  cmp;
  logic [PR_W-1:0]   rd_q   [DEPTH];
  logic [PR_W-1:0]   rdo_q  [DEPTH];
  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   cnt;

  logic             alloc;
  logic             run;
  logic [RW-1:0]    ret_en;
  logic [IDX_W-1:0] slot [RW];
  logic [IDX_W:0]   ret_n;

  assign full       = (cnt == DEPTH_C);
  assign empty      = (cnt == '0);
  assign count      = cnt;
  assign disp_ready = !full;
  assign disp_idx   = tail;
  assign alloc      = disp_valid && !full;

  // Retire window: contiguous prefix of done entries from head.
  always_comb begin
    ret_en = '0;
    ret_n  = '0;
    run    = 1'b1;
    for (int j = 0; j < RW; j++) begin
      slot[j]   = head + IDX_W'(j);
      run       = run & vld[slot[j]]
                      & cmp[slot[j]];
      ret_en[j] = run;
      ret_n     = ret_n
                + {{IDX_W{1'b0}}, run};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld  <= '0;
      cmp  <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      for (int k = 0; k < NWB; k++) begin
        if (wb_valid[k] &&
            vld[wb_idx[k*IDX_W +: IDX_W]])
          cmp[wb_idx[k*IDX_W +: IDX_W]] <= 1'b1;
      end
      for (int j = 0; j < RW; j++) begin
        if (ret_en[j])
          vld[slot[j]] <= 1'b0;
      end
      if (alloc) begin
        vld[tail] <= 1'b1;
        cmp[tail] <= 1'b0;
        tail      <= tail + IDX_W'(1);
      end
      head <= head + ret_n[IDX_W-1:0];
      cnt  <= cnt
            + {{IDX_W{1'b0}}, alloc}
            - ret_n;
    end
  end

  // Payload needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int k = 0; k < NWB; k++) begin
        if (wb_valid[k] &&
            vld[wb_idx[k*IDX_W +: IDX_W]])
          data_q[wb_idx[k*IDX_W +: IDX_W]] <=
            wb_data[k*DATA_W +: DATA_W];
      end
      if (alloc) begin
        rd_q[tail]   <= disp_rd;
        rdo_q[tail]  <= disp_rd_old;
        pc_q[tail]   <= disp_pc;
        data_q[tail] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ret_valid  <= '0;
      ret_rd     <= '0;
      ret_rd_old <= '0;
      ret_data   <= '0;
      ret_pc     <= '0;
    end else begin
      for (int j = 0; j < RW; j++) begin
        ret_valid[j] <= ret_en[j];
        ret_rd[j*PR_W +: PR_W] <=
          ret_en[j] ? rd_q[slot[j]] : '0;
        ret_rd_old[j*PR_W +: PR_W] <=
          ret_en[j] ? rdo_q[slot[j]] : '0;
        ret_data[j*DATA_W +: DATA_W] <=
          ret_en[j] ? data_q[slot[j]] : '0;
        ret_pc[j*PC_W +: PC_W] <=
          ret_en[j] ? pc_q[slot[j]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_rob_param;

  localparam int DEPTH  = 16;
  localparam int NWB    = 3;
  localparam int RW     = 2;
  localparam int DATA_W = 32;
  localparam int PR_W   = 6;
  localparam int PC_W   = 12;
  localparam int IDX_W  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  disp_valid;
  logic                  disp_ready;
  logic [PR_W-1:0]       disp_rd;
  logic [PR_W-1:0]       disp_rd_old;
  logic [PC_W-1:0]       disp_pc;
  logic [IDX_W-1:0]      disp_idx;
  logic [NWB-1:0]        wb_valid;
  logic [NWB*IDX_W-1:0]  wb_idx;
  logic [NWB*DATA_W-1:0] wb_data;
  logic [RW-1:0]         ret_valid;
  logic [RW*PR_W-1:0]    ret_rd;
  logic [RW*PR_W-1:0]    ret_rd_old;
  logic [RW*DATA_W-1:0]  ret_data;
  logic [RW*PC_W-1:0]    ret_pc;
  logic                  flush;
  logic [IDX_W:0]        count;
  logic                  empty;
  logic                  full;

  rob_param dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid),
    .disp_ready(disp_ready),
    .disp_rd(disp_rd),
    .disp_rd_old(disp_rd_old),
    .disp_pc(disp_pc),
    .disp_idx(disp_idx),
    .wb_valid(wb_valid),
    .wb_idx(wb_idx),
    .wb_data(wb_data),
    .ret_valid(ret_valid),
    .ret_rd(ret_rd),
    .ret_rd_old(ret_rd_old),
    .ret_data(ret_data),
    .ret_pc(ret_pc),
    .flush(flush),
    .count(count),
    .empty(empty),
    .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               idx;
    logic [PR_W-1:0]  rd;
    logic [PR_W-1:0]  rdo;
    logic [PC_W-1:0]  pc;
    bit               done;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t q[$];
  int   m_tail;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [RW-1:0]        e_rv;
  logic [RW*PR_W-1:0]   e_rd;
  logic [RW*PR_W-1:0]   e_rdo;
  logic [RW*DATA_W-1:0] e_data;
  logic [RW*PC_W-1:0]   e_pc;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  // Queue model: front is oldest; retire from front, allocate at back.
  function automatic void model();
    int   n;
    ent_t e;
    n      = 0;
    e_rv   = '0;
    e_rd   = '0;
    e_rdo  = '0;
    e_data = '0;
    e_pc   = '0;
    if (rst || flush) begin
      q.delete();
      m_tail = 0;
      return;
    end
    while (n < RW && n < q.size() && q[n].done) begin
      e_rv[n] = 1'b1;
      e_rd[n*PR_W +: PR_W]       = q[n].rd;
      e_rdo[n*PR_W +: PR_W]      = q[n].rdo;
      e_pc[n*PC_W +: PC_W]       = q[n].pc;
      e_data[n*DATA_W +: DATA_W] = q[n].data;
      n++;
    end
    for (int k = 0; k < NWB; k++) begin
      if (wb_valid[k]) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].idx ==
              int'(wb_idx[k*IDX_W +: IDX_W])) begin
            e      = q[i];
            e.done = 1'b1;
            e.data = wb_data[k*DATA_W +: DATA_W];
            q[i]   = e;
          end
        end
      end
    end
    if (disp_valid && q.size() < DEPTH) begin
      e.idx  = m_tail;
      e.rd   = disp_rd;
      e.rdo  = disp_rd_old;
      e.pc   = disp_pc;
      e.done = 1'b0;
      e.data = '0;
      q.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
    repeat (n) void'(q.pop_front());
  endfunction

  task automatic cyc();
    model();
    @(posedge clk);
    #1;
    chk("ret_valid",  64'(ret_valid),  64'(e_rv));
    chk("ret_rd",     64'(ret_rd),     64'(e_rd));
    chk("ret_rd_old", 64'(ret_rd_old), 64'(e_rdo));
    chk("ret_data",   64'(ret_data),   64'(e_data));
    chk("ret_pc",     64'(ret_pc),     64'(e_pc));
    chk("count",      64'(count),      64'(q.size()));
    chk("disp_idx",   64'(disp_idx),   64'(m_tail));
    chk("empty",      64'(empty),      64'(q.size() == 0));
    chk("full",       64'(full),       64'(q.size() == DEPTH));
    chk("disp_ready", 64'(disp_ready), 64'(q.size() != DEPTH));
  endtask

  task automatic idle();
    rst         = 1'b0;
    flush       = 1'b0;
    disp_valid  = 1'b0;
    disp_rd     = '0;
    disp_rd_old = '0;
    disp_pc     = '0;
    wb_valid    = '0;
    wb_idx      = '0;
    wb_data     = '0;
  endtask

  task automatic set_disp(input int rd, input int pc);
    disp_valid  = 1'b1;
    disp_rd     = PR_W'(rd);
    disp_rd_old = PR_W'(rd + 20);
    disp_pc     = PC_W'(pc);
  endtask

  task automatic set_wb(input int k, input int idx,
                        input int d);
    wb_valid[k] = 1'b1;
    wb_idx[k*IDX_W +: IDX_W]    = IDX_W'(idx);
    wb_data[k*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic disp1(input int rd, input int pc);
    idle();
    set_disp(rd, pc);
    cyc();
    idle();
  endtask

  int   nret;
  int   last_idx;
  int   cur;
  int   pos;
  logic [PC_W-1:0] exp_pc;
  bit   at15;

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    idle();
    chk("rst_ready", 64'(disp_ready), 64'd1);
    chk("rst_idx",   64'(disp_idx),   64'd0);
    chk("rst_empty", 64'(empty),      64'd1);

    // Out-of-order completion, in-order retire.
    disp1(10, 'h100);
    disp1(11, 'h104);
    disp1(12, 'h108);
    set_wb(0, 1, 5);
    cyc();
    idle();
    set_wb(0, 0, 7);
    cyc();
    idle();
    chk("d031_none", 64'(ret_valid), 64'd0);
    cyc();
    chk("d031_rv",   64'(ret_valid), 64'b11);
    chk("d031_data", 64'(ret_data),  {32'd5, 32'd7});
    chk("d031_rd",   64'(ret_rd),    {6'd11, 6'd10});
    cyc();
    chk("d031_wait", 64'(ret_valid), 64'd0);
    set_wb(1, 2, 3);
    cyc();
    idle();
    cyc();
    chk("d031_last", 64'(ret_valid), 64'b01);

    // Same-index writeback on two ports: higher port wins.
    disp1(13, 'h10c);
    set_wb(0, 3, 1);
    set_wb(2, 3, 9);
    cyc();
    idle();
    cyc();
    chk("d034_data", 64'(ret_data[31:0]), 64'd9);

    // Writeback to an unallocated index is dropped.
    set_wb(0, 10, 'hdead);
    cyc();
    idle();
    cyc();
    chk("d036_rv",    64'(ret_valid), 64'd0);
    chk("d036_count", 64'(count),     64'd0);

    // Fill to full, then reject further dispatch.
    for (int i = 0; i < DEPTH; i++) disp1(i, 'h300 + i);
    chk("d032_full",  64'(full),       64'd1);
    chk("d032_ready", 64'(disp_ready), 64'd0);
    chk("d032_count", 64'(count),      64'd16);
    set_disp(40, 'h3ff);
    cyc();
    idle();
    chk("d032_idx",   64'(disp_idx), 64'd4);
    chk("d032_cnt2",  64'(count),    64'd16);
    set_wb(0, 4, 'h44);
    cyc();
    idle();
    set_disp(41, 'h3fe);
    cyc();
    idle();
    chk("d027_count", 64'(count),     64'd15);
    chk("d027_idx",   64'(disp_idx),  64'd4);
    chk("d027_rv",    64'(ret_valid), 64'b01);
    flush = 1'b1;
    cyc();
    idle();

    // Flush with dispatch in the same cycle.
    for (int i = 0; i < 5; i++) disp1(i, 'h400 + i);
    set_wb(0, 2, 22);
    set_wb(1, 3, 33);
    cyc();
    idle();
    cyc();
    chk("d035_pre", 64'(count), 64'd5);
    flush = 1'b1;
    set_disp(50, 'h4ff);
    cyc();
    idle();
    chk("d035_count", 64'(count),     64'd0);
    chk("d035_empty", 64'(empty),     64'd1);
    chk("d035_rv",    64'(ret_valid), 64'd0);
    cyc();
    chk("d035_rv2",   64'(ret_valid), 64'd0);
    chk("d035_idx",   64'(disp_idx),  64'd0);

    // Steady stream of 40, wrapping the index twice.
    nret     = 0;
    last_idx = -1;
    pos      = 0;
    exp_pc   = PC_W'('h200);
    at15     = 1'b0;
    for (int c = 0; c < 200 && nret < 40; c++) begin
      idle();
      cur = -1;
      if (pos < 40) begin
        set_disp(pos, 'h200 + pos);
        cur = int'(disp_idx);
      end
      if (last_idx >= 0) set_wb(0, last_idx, pos);
      cyc();
      if (cur == 15) begin
        chk("d033_wrap", 64'(disp_idx), 64'd0);
        at15 = 1'b1;
      end
      last_idx = cur;
      if (pos < 40) pos++;
      for (int j = 0; j < RW; j++) begin
        if (ret_valid[j]) begin
          chk("d033_pc",
              64'(ret_pc[j*PC_W +: PC_W]),
              64'(exp_pc));
          exp_pc = exp_pc + PC_W'(1);
          nret++;
        end
      end
    end
    idle();
    chk("d033_nret", 64'(nret), 64'd40);
    chk("d033_seen", 64'(at15), 64'd1);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(0, 9) < 6)
        set_disp(int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 4095)));
      for (int k = 0; k < NWB; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          if (q.size() > 0 && $urandom_range(0, 3) != 0)
            set_wb(k,
                   q[$urandom_range(0, q.size()-1)].idx,
                   int'($urandom));
          else
            set_wb(k, int'($urandom_range(0, DEPTH-1)),
                   int'($urandom));
        end
      end
      if ($urandom_range(0, 63) == 0) flush = 1'b1;
      cyc();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
